fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined LCA core, producing the `fromPipe1PC`/`fromPipe1IR` pair that the decode stage consumes. It owns the program counter, runs a request/grant/response handshake against instruction memory, and buffers fetched words in a 2-entry queue toward decode. A redirect from a later stage (BEQ taken, JAL, JLR, R7 write-back) flushes the queue, drops in-flight data and restarts fetch at the new PC.

---
 rtl/lca_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 61 ++++++
 rtl/fetch_stage.sv | 128 ++++++++++++
 tb/tb_fetch_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lca_pkg.sv
// lca_pkg: shared types for the LCA core front end.
// Fetch FSM encoding and fetch queue entry layout.
package lca_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_HOLD    = 3'd3,
        ST_DISCARD = 3'd4
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] ir;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry {pc, ir} FIFO between fetch and decode.
// Entry 0 is always the head; flush empties it in one edge.
module fetch_queue
    import lca_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_push,
    input  logic                i_pop,
    input  logic                i_flush,
    input  logic [2*WORD_W-1:0] i_data,
    output logic [2*WORD_W-1:0] o_head,
    output logic [1:0]          o_count
);

    fetch_entry_t r_ent0;
    fetch_entry_t r_ent1;
    logic [1:0]   r_count;
    fetch_entry_t w_din;

    assign w_din = fetch_entry_t'(i_data);

    // Shift-style storage: pops move entry 1 forward, pushes fill the tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ent0  <= '0;
            r_ent1  <= '0;
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_ent0 <= w_din;
                    end else begin
                        r_ent1 <= w_din;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_ent0  <= r_ent1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= w_din;
                    end else begin
                        r_ent0 <= w_din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_head  = (r_count == 2'd0) ? '0 : r_ent0;
    assign o_count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, imem request/grant/response FSM and decode queue.
// One request outstanding at most; redirects flush and restart fetch.
module fetch_stage
    import lca_pkg::*;
#(
    parameter logic [WORD_W-1:0] PC_RESET = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] toPipe1PC,
    output logic [WORD_W-1:0] toPipe1IR,
    output logic              pipe1_valid,
    input  logic              decode_ready,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc
);

    localparam logic [WORD_W-1:0] PC_STEP = 1;

    fetch_state_t        r_state;
    fetch_state_t        w_state_nxt;
    logic [WORD_W-1:0]   r_fetch_pc;
    logic [WORD_W-1:0]   r_inflight_pc;
    logic                w_req;
    logic                w_grant;
    logic                w_push;
    logic                w_pop;
    logic                w_space;
    logic [1:0]          w_count;
    logic [2*WORD_W-1:0] w_head;

    assign w_grant = w_req & imem_gnt;
    assign w_pop   = pipe1_valid & decode_ready;
    assign w_push  = (r_state == ST_WAIT) & imem_rvalid & ~redirect_valid;
    // A new request is safe only if the queue cannot hold 2 when it returns.
    assign w_space = (w_count == 2'd0) | w_pop;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and request decode.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                w_req = 1'b1;
                if (imem_gnt) begin
                    w_state_nxt = redirect_valid ? ST_DISCARD : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    w_state_nxt = imem_rvalid ? ST_REQ : ST_DISCARD;
                end else if (imem_rvalid) begin
                    if (w_space) begin
                        w_req       = 1'b1;
                        w_state_nxt = imem_gnt ? ST_WAIT : ST_REQ;
                    end else begin
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_valid || (w_count != 2'd2)) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_DISCARD: begin
                if (imem_rvalid) begin
                    w_state_nxt = ST_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Fetch PC and in-flight PC; a redirect overrides the grant increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= PC_RESET;
            r_inflight_pc <= PC_RESET;
        end else begin
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
            end else if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + PC_STEP;
            end
            if (w_grant) begin
                r_inflight_pc <= r_fetch_pc;
            end
        end
    end

    fetch_queue u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  ({r_inflight_pc, imem_rdata}),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign imem_req    = w_req;
    assign imem_addr   = r_fetch_pc;
    assign pipe1_valid = (w_count != 2'd0) & ~redirect_valid;
    assign toPipe1PC   = w_head[2*WORD_W-1:WORD_W];
    assign toPipe1IR   = w_head[WORD_W-1:0];

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table, directed corner cases and random
// traffic against an in-order instruction stream reference.
module tb_fetch_stage;

    localparam logic [15:0] PC_RESET = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = 16'h0;
    logic [15:0] toPipe1PC;
    logic [15:0] toPipe1IR;
    logic        pipe1_valid;
    logic        decode_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0;

    always #5 clk = ~clk;

    fetch_stage #(.PC_RESET(PC_RESET)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .toPipe1PC      (toPipe1PC),
        .toPipe1IR      (toPipe1IR),
        .pipe1_valid    (pipe1_valid),
        .decode_ready   (decode_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    int checks = 0;
    int errors = 0;

    // memory model and stream reference state
    int          cyc;
    int          lat;
    int          gnt_pct;
    logic        gnt_block;
    logic [15:0] pend_addr[$];
    int          pend_due[$];
    logic [15:0] exp_pc;
    logic [15:0] got_pc[$];
    logic [15:0] got_ir[$];
    logic        prev_hold;
    logic        prev_wait;
    logic [15:0] prev_pc;
    logic [15:0] prev_ir;
    logic [15:0] prev_addr;
    logic        obs_req;
    logic        obs_gnt;
    logic        obs_valid;
    logic [15:0] obs_addr;
    logic [15:0] obs_pc;
    logic [15:0] obs_ir;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        req;
        logic [15:0] addr;
        logic        vld;
        logic [15:0] pc;
        logic [15:0] ir;
    } vec_t;

    vec_t tbl[19];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a + 16'h1000;
    endfunction

    task automatic check(input string name, input logic ok, input string msg);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, msg);
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 16'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
        decode_ready   = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        got_pc.delete();
        got_ir.delete();
        prev_hold = 1'b0;
        prev_wait = 1'b0;
        gnt_block = 1'b0;
        exp_pc    = PC_RESET;
        cyc       = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One clock cycle, entered and left 1 time unit after a rising edge.
    task automatic tick(input logic red, input logic [15:0] rpc,
                        input logic rdy);
        logic g;
        redirect_valid = red;
        redirect_pc    = rpc;
        decode_ready   = rdy;
        imem_rvalid    = 1'b0;
        imem_rdata     = 16'h0;
        imem_gnt       = 1'b0;
        if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        #1;
        g = imem_req && !gnt_block && ($urandom_range(99) < gnt_pct);
        imem_gnt = g;
        #1;
        obs_req   = imem_req;
        obs_gnt   = g;
        obs_addr  = imem_addr;
        obs_valid = pipe1_valid;
        obs_pc    = toPipe1PC;
        obs_ir    = toPipe1IR;
        if (red) begin
            check("redirect_gate", !pipe1_valid,
                  $sformatf("pipe1_valid=%b required 0", pipe1_valid));
        end
        if (prev_hold && !red) begin
            check("head_stable",
                  pipe1_valid && toPipe1PC == prev_pc && toPipe1IR == prev_ir,
                  $sformatf("v=%b pc=%h ir=%h required v=1 pc=%h ir=%h",
                            pipe1_valid, toPipe1PC, toPipe1IR, prev_pc, prev_ir));
        end
        if (prev_wait) begin
            check("addr_stable", imem_req && imem_addr == prev_addr,
                  $sformatf("req=%b addr=%h required req=1 addr=%h",
                            imem_req, imem_addr, prev_addr));
        end
        if (pipe1_valid && rdy) begin
            check("deliver",
                  toPipe1PC == exp_pc && toPipe1IR == mem_word(exp_pc),
                  $sformatf("pc=%h ir=%h required pc=%h ir=%h",
                            toPipe1PC, toPipe1IR, exp_pc, mem_word(exp_pc)));
            got_pc.push_back(toPipe1PC);
            got_ir.push_back(toPipe1IR);
            exp_pc = exp_pc + 16'h1;
        end
        if (red) exp_pc = rpc;
        if (g) begin
            check("one_outstanding", pend_due.size() == 0,
                  $sformatf("outstanding=%0d required 0", pend_due.size()));
            pend_addr.push_back(imem_addr);
            pend_due.push_back(cyc + lat);
        end
        prev_hold = pipe1_valid && !rdy;
        prev_pc   = toPipe1PC;
        prev_ir   = toPipe1IR;
        prev_wait = imem_req && !g && !red;
        prev_addr = imem_addr;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_dlv(input int n, input string name);
        int i;
        i = 0;
        while (got_pc.size() < n && i < 200) begin
            tick(1'b0, 16'h0, 1'b1);
            i++;
        end
        check(name, got_pc.size() >= n,
              $sformatf("delivered=%0d required %0d", got_pc.size(), n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        logic        red;
        logic [15:0] rpc;

        // {rst, rdy, req, addr, vld, pc, ir}: 1-cycle memory, always grant
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0000, 16'h0000};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h0000, 16'h1000};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 16'h0003, 1'b1, 16'h0001, 16'h1001};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h0002, 16'h1002};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 16'h0005, 1'b1, 16'h0003, 16'h1003};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 16'h0000, 16'h0000};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 16'h0000, 16'h1000};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 16'h0000, 16'h1000};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 16'h0000, 16'h1000};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 16'h0000, 16'h1000};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 16'h0002, 1'b1, 16'h0000, 16'h1000};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 16'h0002, 1'b1, 16'h0001, 16'h1001};
        tbl[16] = '{1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 16'h0000, 16'h0000};
        tbl[17] = '{1'b0, 1'b1, 1'b1, 16'h0003, 1'b0, 16'h0000, 16'h0000};
        tbl[18] = '{1'b0, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h0002, 16'h1002};

        lat     = 1;
        gnt_pct = 100;
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            tick(1'b0, 16'h0, tbl[i].rdy);
            check($sformatf("vec%0d", i),
                  obs_req == tbl[i].req && obs_addr == tbl[i].addr &&
                  obs_valid == tbl[i].vld && obs_pc == tbl[i].pc &&
                  obs_ir == tbl[i].ir,
                  $sformatf("req=%b addr=%h v=%b pc=%h ir=%h required req=%b addr=%h v=%b pc=%h ir=%h",
                            obs_req, obs_addr, obs_valid, obs_pc, obs_ir,
                            tbl[i].req, tbl[i].addr, tbl[i].vld,
                            tbl[i].pc, tbl[i].ir));
        end

        // redirect while waiting on a 3-cycle response
        do_reset();
        lat     = 3;
        gnt_pct = 100;
        tick(1'b0, 16'h0, 1'b1);
        tick(1'b0, 16'h0, 1'b1);
        tick(1'b1, 16'h0040, 1'b1);
        k = 0;
        do begin
            tick(1'b0, 16'h0, 1'b1);
            k++;
        end while (!obs_req && k < 20);
        check("wait_redirect_addr", obs_req && obs_addr == 16'h0040,
              $sformatf("req=%b addr=%h required req=1 addr=0040",
                        obs_req, obs_addr));
        run_dlv(1, "wait_redirect_dlv");
        if (got_pc.size() > 0) begin
            check("wait_redirect_head",
                  got_pc[0] == 16'h0040 && got_ir[0] == 16'h1040,
                  $sformatf("pc=%h ir=%h required pc=0040 ir=1040",
                            got_pc[0], got_ir[0]));
        end

        // redirect in the same cycle as the grant for PC 5
        do_reset();
        lat     = 1;
        gnt_pct = 100;
        k = 0;
        while (imem_addr != 16'h0005 && k < 20) begin
            tick(1'b0, 16'h0, 1'b1);
            k++;
        end
        check("gnt_redirect_reach", imem_addr == 16'h0005,
              $sformatf("addr=%h required 0005", imem_addr));
        gnt_block = 1'b1;
        tick(1'b0, 16'h0, 1'b1);
        gnt_block = 1'b0;
        tick(1'b1, 16'h0010, 1'b1);
        check("gnt_redirect_cycle",
              obs_req && obs_gnt && obs_addr == 16'h0005 && !obs_valid,
              $sformatf("req=%b gnt=%b addr=%h v=%b required req=1 gnt=1 addr=0005 v=0",
                        obs_req, obs_gnt, obs_addr, obs_valid));
        got_pc.delete();
        got_ir.delete();
        run_dlv(1, "gnt_redirect_dlv");
        if (got_pc.size() > 0) begin
            check("gnt_redirect_head",
                  got_pc[0] == 16'h0010 && got_ir[0] == 16'h1010,
                  $sformatf("pc=%h ir=%h required pc=0010 ir=1010",
                            got_pc[0], got_ir[0]));
        end

        // PC wrap from FFFF to 0000
        do_reset();
        lat     = 1;
        gnt_pct = 100;
        tick(1'b1, 16'hFFFF, 1'b1);
        run_dlv(2, "wrap_dlv");
        if (got_pc.size() > 1) begin
            check("wrap_seq",
                  got_pc[0] == 16'hFFFF && got_ir[0] == 16'h0FFF &&
                  got_pc[1] == 16'h0000 && got_ir[1] == 16'h1000,
                  $sformatf("pcs=%h,%h irs=%h,%h required FFFF,0000 0FFF,1000",
                            got_pc[0], got_pc[1], got_ir[0], got_ir[1]));
        end

        // asynchronous reset while a response is outstanding
        do_reset();
        lat     = 3;
        gnt_pct = 100;
        repeat (6) tick(1'b0, 16'h0, 1'b0);
        check("areset_setup", obs_valid && pend_due.size() == 1,
              $sformatf("v=%b outstanding=%0d required v=1 outstanding=1",
                        obs_valid, pend_due.size()));
        rst_n = 1'b0;
        #1;
        check("areset_outputs",
              !imem_req && imem_addr == PC_RESET && !pipe1_valid &&
              toPipe1PC == 16'h0 && toPipe1IR == 16'h0,
              $sformatf("req=%b addr=%h v=%b pc=%h ir=%h required 0 %h 0 0000 0000",
                        imem_req, imem_addr, pipe1_valid, toPipe1PC,
                        toPipe1IR, PC_RESET));
        do_reset();
        lat = 1;
        run_dlv(1, "areset_restart");
        if (got_pc.size() > 0) begin
            check("areset_head",
                  got_pc[0] == PC_RESET && got_ir[0] == mem_word(PC_RESET),
                  $sformatf("pc=%h ir=%h required pc=%h ir=%h",
                            got_pc[0], got_ir[0], PC_RESET,
                            mem_word(PC_RESET)));
        end

        // random latency, grant, backpressure and redirects
        for (int r = 0; r < 4; r++) begin
            do_reset();
            lat     = $urandom_range(1, 4);
            gnt_pct = $urandom_range(40, 100);
            for (int c = 0; c < 400; c++) begin
                red = ($urandom_range(39) == 0);
                if ($urandom_range(3) == 0) begin
                    rpc = 16'hFFFC + 16'($urandom_range(3));
                end else begin
                    rpc = 16'($urandom);
                end
                tick(red, rpc, $urandom_range(3) != 0);
            end
            check($sformatf("rand_progress%0d", r), got_pc.size() > 10,
                  $sformatf("delivered=%0d required >10", got_pc.size()));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
